// File: rtl/axi4stream_frame_generator.sv
// Generic synchronous FIFO with the head word always presented on head_dat.
// Latency: a word pushed at edge N appears on head_dat from cycle N+1 when the FIFO was empty.
// Backpressure: none internally; the caller never pushes when full or pops when empty.
module frame_gen_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage and write pointer; storage is cleared so the head reads 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
        end else if (push) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
        end
    end

    // Read pointer advances on every pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
        end else if (pop) begin
            rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
        end
    end

    // Occupancy: simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_dat = mem[rd_ptr];

endmodule

// Pixel stream to AXI4-Stream video frame bridge, one frame per start, SOF on first beat, tlast per row.
// Latency: one cycle from sink handshake to tvalid (2-entry buffer).
// Backpressure: tready stalls the buffer; sink_ready drops when buffer full, frame quota taken, or not ACTIVE.
module axi4stream_frame_generator #(
    parameter int TOTAL_COLS = 224,
    parameter int TOTAL_ROWS = 224
) (
    input  logic        clock_sink_clk,
    input  logic        reset_sink_reset_n,
    input  logic [23:0] avalon_streaming_sink_data,
    input  logic        avalon_streaming_sink_valid,
    output logic        avalon_streaming_sink_ready,
    output logic [23:0] axi4stream_master_tdata,
    output logic        axi4stream_master_tvalid,
    input  logic        axi4stream_master_tready,
    output logic [2:0]  axi4stream_master_tuser,
    output logic        axi4stream_master_tlast,
    input  logic        start_flag,
    output logic        frame_busy,
    output logic        frame_done,
    output logic        led_out
);
    localparam int FRAME_BEATS = TOTAL_COLS * TOTAL_ROWS;
    localparam int IN_W  = ($clog2(FRAME_BEATS + 1) > 16) ? $clog2(FRAME_BEATS + 1) : 16;
    localparam int COL_W = (TOTAL_COLS > 1) ? $clog2(TOTAL_COLS) : 1;
    localparam int ROW_W = (TOTAL_ROWS > 1) ? $clog2(TOTAL_ROWS) : 1;
    localparam logic [IN_W-1:0]  IN_LIMIT = IN_W'(FRAME_BEATS);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(TOTAL_COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(TOTAL_ROWS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IN_W-1:0]  in_cnt;
    logic [COL_W-1:0] col_cnt;
    logic [ROW_W-1:0] row_cnt;
    logic [1:0]       occupancy;
    logic [23:0]      head;
    logic             push;
    logic             pop;
    logic             col_end;
    logic             row_end;
    logic             frame_end;
    logic             start_accept;

    assign push         = avalon_streaming_sink_valid & avalon_streaming_sink_ready;
    assign pop          = axi4stream_master_tvalid & axi4stream_master_tready;
    assign col_end      = (col_cnt == COL_LAST);
    assign row_end      = (row_cnt == ROW_LAST);
    assign frame_end    = pop & col_end & row_end;
    assign start_accept = (state == ST_IDLE) & start_flag;

    frame_gen_fifo #(
        .WIDTH (24),
        .DEPTH (2),
        .CNT_W (2)
    ) u_fifo (
        .clk      (clock_sink_clk),
        .rst_n    (reset_sink_reset_n),
        .push     (push),
        .push_dat (avalon_streaming_sink_data),
        .pop      (pop),
        .head_dat (head),
        .count    (occupancy)
    );

    // Frame state register.
    always_ff @(posedge clock_sink_clk or negedge reset_sink_reset_n) begin
        if (!reset_sink_reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and state-decoded outputs; the quota term stops the block taking
    // pixels that belong to the next frame.
    always_comb begin
        state_next                  = state;
        frame_busy                  = 1'b0;
        frame_done                  = 1'b0;
        avalon_streaming_sink_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_flag) begin
                    state_next = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                frame_busy                  = 1'b1;
                avalon_streaming_sink_ready = (occupancy < 2'd2) & (in_cnt < IN_LIMIT);
                if (frame_end) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                frame_done = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Input quota counter: restarts with each frame, back to 0 once the frame completes.
    always_ff @(posedge clock_sink_clk or negedge reset_sink_reset_n) begin
        if (!reset_sink_reset_n) begin
            in_cnt <= '0;
        end else if (start_accept || frame_end) begin
            in_cnt <= '0;
        end else if (push) begin
            in_cnt <= in_cnt + 1'b1;
        end
    end

    // Output raster position, advanced per transferred beat.
    always_ff @(posedge clock_sink_clk or negedge reset_sink_reset_n) begin
        if (!reset_sink_reset_n) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (pop) begin
            if (col_end) begin
                col_cnt <= '0;
                row_cnt <= row_end ? '0 : row_cnt + 1'b1;
            end else begin
                col_cnt <= col_cnt + 1'b1;
            end
        end
    end

    // Frame indicator LED flips once per completed frame.
    always_ff @(posedge clock_sink_clk or negedge reset_sink_reset_n) begin
        if (!reset_sink_reset_n) begin
            led_out <= 1'b0;
        end else if (state == ST_DONE) begin
            led_out <= ~led_out;
        end
    end

    assign axi4stream_master_tvalid = (occupancy != 2'd0);
    assign axi4stream_master_tdata  = head;
    assign axi4stream_master_tuser  = {2'b00, axi4stream_master_tvalid & (col_cnt == '0) & (row_cnt == '0)};
    assign axi4stream_master_tlast  = axi4stream_master_tvalid & col_end;

endmodule

// File: tb/tb_axi4stream_frame_generator.sv
module tb_axi4stream_frame_generator;
    localparam int C = 4;
    localparam int R = 3;
    localparam int F = C * R;

    typedef struct packed {
        logic [23:0] d;
        logic        sof;
        logic        last;
        logic        eof;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [23:0] sdata = '0;
    logic        svalid = 1'b0;
    logic        sready;
    logic [23:0] tdata;
    logic        tvalid;
    logic        tready = 1'b1;
    logic [2:0]  tuser;
    logic        tlast;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic        led;

    logic [23:0] b_sdata = '0;
    logic        b_svalid = 1'b1;
    logic        b_sready;
    logic [23:0] b_tdata;
    logic        b_tvalid;
    logic        b_tready = 1'b1;
    logic [2:0]  b_tuser;
    logic        b_tlast;
    logic        b_start = 1'b0;
    logic        b_busy;
    logic        b_done;
    logic        b_led;

    always #5 clk = ~clk;

    axi4stream_frame_generator #(.TOTAL_COLS(C), .TOTAL_ROWS(R)) u_dut (
        .clock_sink_clk              (clk),
        .reset_sink_reset_n          (rst_n),
        .avalon_streaming_sink_data  (sdata),
        .avalon_streaming_sink_valid (svalid),
        .avalon_streaming_sink_ready (sready),
        .axi4stream_master_tdata     (tdata),
        .axi4stream_master_tvalid    (tvalid),
        .axi4stream_master_tready    (tready),
        .axi4stream_master_tuser     (tuser),
        .axi4stream_master_tlast     (tlast),
        .start_flag                  (start),
        .frame_busy                  (busy),
        .frame_done                  (done),
        .led_out                     (led)
    );

    axi4stream_frame_generator u_big (
        .clock_sink_clk              (clk),
        .reset_sink_reset_n          (rst_n),
        .avalon_streaming_sink_data  (b_sdata),
        .avalon_streaming_sink_valid (b_svalid),
        .avalon_streaming_sink_ready (b_sready),
        .axi4stream_master_tdata     (b_tdata),
        .axi4stream_master_tvalid    (b_tvalid),
        .axi4stream_master_tready    (b_tready),
        .axi4stream_master_tuser     (b_tuser),
        .axi4stream_master_tlast     (b_tlast),
        .start_flag                  (b_start),
        .frame_busy                  (b_busy),
        .frame_done                  (b_done),
        .led_out                     (b_led)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the output stream is the offered pixel sequence in order,
    // with frame markers derived from each pixel's position in the sequence.
    logic [23:0] src_q[$];
    beat_t       exp_q[$];
    int          model_idx = 0;

    task automatic offer(input logic [23:0] d);
        beat_t e;
        int    pos;
        pos    = model_idx % F;
        e.d    = d;
        e.sof  = (pos == 0);
        e.last = ((pos % C) == C - 1);
        e.eof  = (pos == F - 1);
        src_q.push_back(d);
        exp_q.push_back(e);
        model_idx++;
    endtask

    // Source: presents queued pixels, holding each until accepted.
    logic in_fire = 1'b0;
    logic gap_en = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (svalid && in_fire) svalid = 1'b0;
            if (!svalid && src_q.size() != 0 && (!gap_en || $urandom_range(0, 2) != 0)) begin
                sdata  = src_q.pop_front();
                svalid = 1'b1;
            end
        end
    end

    // Downstream ready: 0 = always, 1 = pattern 1,0,0,1, 2 = random.
    int       rdy_mode = 0;
    logic [3:0] rdy_pat = 4'b1001;
    initial begin
        int cyc;
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       tready = rdy_pat[cyc % 4];
                2:       tready = 1'($urandom_range(0, 1));
                default: tready = 1'b1;
            endcase
            cyc++;
        end
    end

    // Monitor / scoreboard.
    logic        out_fire = 1'b0;
    logic        last_prev = 1'b0;
    logic        done_prev = 1'b0;
    logic        led_exp = 1'b0;
    logic        stall_prev = 1'b0;
    logic [23:0] stall_dat = '0;
    logic        busy_prev = 1'b0;
    logic        gap_armed = 1'b0;
    logic        gap_chk_en = 1'b0;
    int          gap_len = 0;
    int          acc_cnt = 0;
    int          pop_cnt = 0;
    int          beat_cnt = 0;
    int          sof_cnt = 0;
    int          tlast_cnt = 0;
    int          done_cnt = 0;
    int          busy_rise_cnt = 0;
    beat_t       e_m;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_fire    = 1'b0;
            out_fire   = 1'b0;
            last_prev  = 1'b0;
            done_prev  = 1'b0;
            led_exp    = 1'b0;
            stall_prev = 1'b0;
            busy_prev  = 1'b0;
            gap_armed  = 1'b0;
            gap_len    = 0;
            acc_cnt    = 0;
            pop_cnt    = 0;
        end else begin
            check("frame_done", done, last_prev);
            if (done_prev) led_exp = ~led_exp;
            check("led_out", led, led_exp);
            done_prev = last_prev;
            if (stall_prev) begin
                check("stall_tvalid", tvalid, 1);
                check("stall_tdata", tdata, stall_dat);
            end
            check("tvalid_occ", tvalid, acc_cnt != pop_cnt);
            if (acc_cnt - pop_cnt >= 2) check("ready_when_full", sready, 0);
            if (!tvalid) begin
                check("idle_tuser", tuser, 0);
                check("idle_tlast", tlast, 0);
            end
            last_prev = 1'b0;
            out_fire  = tvalid && tready;
            in_fire   = svalid && sready;
            if (out_fire) begin
                beat_cnt++;
                pop_cnt++;
                if (tuser[0]) sof_cnt++;
                if (tlast) tlast_cnt++;
                check("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e_m = exp_q.pop_front();
                    check("tdata", tdata, e_m.d);
                    check("tuser_sof", tuser[0], e_m.sof);
                    check("tuser_hi", tuser[2:1], 0);
                    check("tlast", tlast, e_m.last);
                    last_prev = e_m.eof;
                end
            end
            if (in_fire) acc_cnt++;
            stall_prev = tvalid && !tready;
            stall_dat  = tdata;
            if (done) done_cnt++;
            if (busy) begin
                if (!busy_prev) begin
                    busy_rise_cnt++;
                    if (gap_chk_en && gap_armed) check("frame_gap", gap_len, 2);
                end
                gap_len   = 0;
                gap_armed = gap_chk_en;
            end else begin
                gap_len++;
            end
            busy_prev = busy;
        end
    end

    // Default-size instance: continuous source, counting data.
    logic        b_in_fire = 1'b0;
    logic [23:0] b_expd = '0;
    int          b_beats = 0;
    int          b_tlasts = 0;
    int          b_sofs = 0;
    int          b_dones = 0;
    int          b_err = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (b_tvalid && b_tready) begin
                b_beats++;
                if (b_tdata !== b_expd) b_err++;
                b_expd = b_expd + 24'd1;
                if (b_tlast) b_tlasts++;
                if (b_tuser[0]) b_sofs++;
            end
            if (b_done) b_dones++;
            b_in_fire = b_svalid && b_sready;
        end else begin
            b_in_fire = 1'b0;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (b_in_fire) b_sdata = b_sdata + 24'd1;
        end
    end

    task automatic start_pulse();
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_ready", sready, 1);
    endtask

    task automatic wait_done(input int target, input string name);
        int c;
        c = 0;
        while (done_cnt < target && c < 600) begin
            @(posedge clk);
            c++;
        end
        check(name, done_cnt >= target, 1);
        repeat (2) @(posedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tdata"}, tdata, 0);
        check({tag, "_tvalid"}, tvalid, 0);
        check({tag, "_tuser"}, tuser, 0);
        check({tag, "_tlast"}, tlast, 0);
        check({tag, "_sready"}, sready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_led"}, led, 0);
    endtask

    initial begin
        int base_done;
        int base_sof;
        int base_tlast;
        int base_beat;
        int base_rise;
        int c;

        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // A: pixels 1..12, continuous ready, start pulse.
        base_done  = done_cnt;
        base_sof   = sof_cnt;
        base_tlast = tlast_cnt;
        for (int i = 1; i <= F; i++) offer(24'(i));
        start_pulse();
        wait_done(base_done + 1, "A_timeout");
        check("A_sof_count", sof_cnt - base_sof, 1);
        check("A_tlast_count", tlast_cnt - base_tlast, R);
        check("A_done_count", done_cnt - base_done, 1);
        check("A_led", led, 1);
        check("A_leftover", exp_q.size(), 0);

        // B: same frame shape, random data, ready pattern 1,0,0,1.
        rdy_mode  = 1;
        base_done = done_cnt;
        for (int i = 0; i < F; i++) offer(24'($urandom));
        start_pulse();
        wait_done(base_done + 1, "B_timeout");
        check("B_leftover", exp_q.size(), 0);
        rdy_mode = 0;

        // C: 20 pixels offered for one start; excess held until the next start.
        base_done = done_cnt;
        base_beat = beat_cnt;
        for (int i = 0; i < 20; i++) offer(24'($urandom));
        start_pulse();
        wait_done(base_done + 1, "C_timeout");
        check("C_first_frame_beats", beat_cnt - base_beat, F);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("C_ready_held_off", sready, 0);
        end
        for (int i = 0; i < 4; i++) offer(24'($urandom));
        start_pulse();
        wait_done(base_done + 2, "C2_timeout");
        check("C_leftover", exp_q.size(), 0);

        // D: start held high, three back-to-back frames, random gaps and ready.
        gap_en     = 1'b1;
        rdy_mode   = 2;
        gap_chk_en = 1'b1;
        base_done  = done_cnt;
        base_rise  = busy_rise_cnt;
        for (int i = 0; i < 3 * F; i++) offer(24'($urandom));
        @(posedge clk);
        #1 start = 1'b1;
        c = 0;
        while (busy_rise_cnt < base_rise + 3 && c < 1500) begin
            @(posedge clk);
            c++;
        end
        #1 start = 1'b0;
        check("D_rise_timeout", busy_rise_cnt >= base_rise + 3, 1);
        wait_done(base_done + 3, "D_timeout");
        check("D_done_count", done_cnt - base_done, 3);
        check("D_leftover", exp_q.size(), 0);
        gap_chk_en = 1'b0;
        gap_en     = 1'b0;
        rdy_mode   = 0;

        // E: reset after five output beats, then a clean frame.
        base_beat = beat_cnt;
        for (int i = 0; i < F; i++) offer(24'($urandom));
        start_pulse();
        c = 0;
        while (beat_cnt < base_beat + 5 && c < 200) begin
            @(posedge clk);
            c++;
        end
        check("E_beat_timeout", beat_cnt >= base_beat + 5, 1);
        #2 rst_n = 1'b0;
        svalid = 1'b0;
        sdata  = '0;
        src_q.delete();
        exp_q.delete();
        model_idx = 0;
        #1 check_reset_outputs("midreset");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        base_done = done_cnt;
        for (int i = 0; i < F; i++) offer(24'($urandom));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("E_idle_busy", busy, 0);
            check("E_idle_ready", sready, 0);
        end
        start_pulse();
        wait_done(base_done + 1, "E_timeout");
        check("E_led", led, 1);
        check("E_leftover", exp_q.size(), 0);

        // F: default 224x224 frame, continuous data.
        @(posedge clk);
        #1 b_start = 1'b1;
        @(posedge clk);
        #1 b_start = 1'b0;
        c = 0;
        while (b_dones < 1 && c < 60000) begin
            @(posedge clk);
            c++;
        end
        repeat (4) @(posedge clk);
        check("big_beats", b_beats, 50176);
        check("big_tlast", b_tlasts, 224);
        check("big_sof", b_sofs, 1);
        check("big_done", b_dones, 1);
        check("big_data_errors", b_err, 0);
        check("big_led", b_led, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi4stream_frame_generator.md
# axi4stream_frame_generator

Return-path bridge that accepts a stream of 24-bit pixels on an Avalon-ST sink and emits one complete AXI4-Stream video frame of TOTAL_COLS × TOTAL_ROWS beats on an AXI4-Stream master. It marks the first beat with start-of-frame (tuser[0]) and the last beat of each row with tlast. It sits between the inference/processing output and the downstream AXI4-Stream video pipeline. It is the transmit-side counterpart of the frame-capturing AXI4-Stream-to-Avalon bridge. Frames are gated by start_flag, and a 2-entry buffer absorbs backpressure without dropping pixels.

## Interface
- TOTAL_COLS, 224, beats per row; tlast is asserted on beat TOTAL_COLS-1 of each row.
- TOTAL_ROWS, 224, rows per frame.
- clock_sink_clk  in  1  single clock; all logic is on its rising edge.
- reset_sink_reset_n  in  1  reset, asynchronous assert, active-low.
- avalon_streaming_sink_data  in  24  pixel input.
- avalon_streaming_sink_valid  in  1  input beat valid.
- avalon_streaming_sink_ready  out  1  input accept; ready latency 0.
- axi4stream_master_tdata  out  24  pixel output.
- axi4stream_master_tvalid  out  1  output beat valid.
- axi4stream_master_tready  in  1  downstream accept.
- axi4stream_master_tuser  out  3  [0] = start-of-frame; [1] and [2] = 0 (video data, never a control packet).
- axi4stream_master_tlast  out  1  end of row.
- start_flag  in  1  level or pulse; sampled in IDLE only.
- frame_busy  out  1  high while in ACTIVE.
- frame_done  out  1  one-cycle pulse after the last beat of the frame is transferred.
- led_out  out  1  toggles once per completed frame.

## Operation
- States:
  - IDLE: ready=0; holds until start_flag=1, then goes to ACTIVE.
  - ACTIVE: moves pixels.
  - DONE: one cycle, frame_done=1, led_out toggles; then returns to IDLE.
- Input counter in_cnt, range 0..TOTAL_COLS·TOTAL_ROWS, 16 bits minimum:
  - cleared on the IDLE→ACTIVE transition;
  - incremented on each input handshake (sink_valid & sink_ready).
- avalon_streaming_sink_ready = (state==ACTIVE) & (occupancy<2) & (in_cnt < TOTAL_COLS·TOTAL_ROWS). The block never accepts more pixels than one frame. Excess upstream data is held off until the next start.
- Buffer: 2-entry FIFO.
  - Push on an input handshake; pop on tvalid & tready.
  - Push and pop in the same cycle leave occupancy unchanged.
  - No push is possible at occupancy 2 because ready=0.
- tvalid = occupancy≠0. tdata = FIFO head. tdata/tvalid are stable while tvalid=1 and tready=0.
- Output counters col_cnt (0..TOTAL_COLS-1) and row_cnt (0..TOTAL_ROWS-1) advance on each output handshake:
  - col_cnt wraps to 0 at TOTAL_COLS-1 and increments row_cnt at the same time;
  - row_cnt wraps to 0 at TOTAL_ROWS-1.
- tuser[0] = tvalid & col_cnt==0 & row_cnt==0.
- tlast = tvalid & col_cnt==TOTAL_COLS-1.
- An output handshake at row_cnt==TOTAL_ROWS-1, col_cnt==TOTAL_COLS-1 causes ACTIVE→DONE on the next edge. At that point the FIFO is empty and all counters are 0.
- start_flag is ignored in ACTIVE and DONE. A start_flag held high in IDLE starts the next frame immediately, giving back-to-back frames with one DONE cycle and one IDLE cycle between them.

## Timing
- Reset: all outputs 0 (tdata=0, tuser=0, tlast=0, tvalid=0, sink_ready=0, frame_busy=0, frame_done=0, led_out=0); state=IDLE; counters and FIFO cleared.
- Reset asserted mid-frame discards buffered data. After deassertion the block waits in IDLE for start_flag.
- start_flag high at edge N gives state=ACTIVE and sink_ready=1 from cycle N+1.
- Latency: a pixel accepted at edge N is presented on tvalid from cycle N+1 (one register stage).
- Throughput: one beat per cycle when sink_valid and tready are both continuously high.
- The final output handshake at edge M gives frame_done=1 during cycle M+1 and state=IDLE at M+2. led_out changes at edge M+1.

## Test plan
- TOTAL_COLS=4, TOTAL_ROWS=3, pixels 1..12, tready=1, start pulse:
  - 12 output beats, data 1..12;
  - tuser[0]=1 on beat 1 only;
  - tlast on beats 4, 8, 12;
  - frame_done pulses once; led_out goes 0→1.
- Same frame with tready toggling 1,0,0,1,…:
  - no data lost or duplicated;
  - tdata stable while stalled;
  - sink_ready=0 whenever occupancy is 2.
- Upstream offers 20 pixels, one start: exactly 12 accepted; sink_ready=0 after the 12th until the next start_flag; beats 13..20 form the next frame.
- start_flag held high: back-to-back frames with exactly 2 non-ACTIVE cycles between them; led_out toggles per frame.
- Reset asserted after beat 5: all outputs 0 immediately. After release with start_flag: the next beat carries tuser[0]=1 and col/row restart at 0.
- Default parameters, continuous data: 50176 beats, 224 tlast pulses, one SOF, one frame_done.
